axis_packet_arbiter: RTL

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_packet_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter: merges NUM_INPUTS requesters onto one stream,
// holding each grant until the granted packet's tlast handshake.
module axis_packet_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int ID_WIDTH    = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int TKEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_INPUTS*ID_WIDTH-1:0]      s_axis_tid_i,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]    s_axis_tdata_i,
    input  logic [NUM_INPUTS*TKEEP_WIDTH-1:0]   s_axis_tkeep_i,
    input  logic [NUM_INPUTS-1:0]               s_axis_tlast_i,
    input  logic [NUM_INPUTS-1:0]               s_axis_tvalid_i,
    output logic [NUM_INPUTS-1:0]               s_axis_tready_o,
    input  logic [NUM_INPUTS-1:0]               enable_i,
    output logic [ID_WIDTH-1:0]                 m_axis_tid_o,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata_o,
    output logic [TKEEP_WIDTH-1:0]              m_axis_tkeep_o,
    output logic                                m_axis_tlast_o,
    output logic                                m_axis_tvalid_o,
    input  logic                                m_axis_tready_i,
    output logic [$clog2(NUM_INPUTS)-1:0]       grant_o,
    output logic                                busy_o,
    output logic [31:0]                         pkt_cnt_o
);

    localparam int GW = $clog2(NUM_INPUTS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [GW-1:0]   grant_r, grant_s;
    logic [GW-1:0]   last_grant_r, last_grant_s;
    logic [31:0]     pkt_cnt_r, pkt_cnt_s;

    logic [NUM_INPUTS-1:0] req_s;
    logic [GW-1:0]         pick_s;
    logic [GW-1:0]         cand_s;
    logic                  found_s;

    logic [ID_WIDTH-1:0]    tid_arr_s   [NUM_INPUTS];
    logic [DATA_WIDTH-1:0]  tdata_arr_s [NUM_INPUTS];
    logic [TKEEP_WIDTH-1:0] tkeep_arr_s [NUM_INPUTS];

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_unpack
        assign tid_arr_s[k]   = s_axis_tid_i[k*ID_WIDTH +: ID_WIDTH];
        assign tdata_arr_s[k] = s_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign tkeep_arr_s[k] = s_axis_tkeep_i[k*TKEEP_WIDTH +: TKEEP_WIDTH];
    end

    // Round-robin search: first active request above last_grant, wrapping.
    always_comb begin
        req_s   = s_axis_tvalid_i & enable_i;
        pick_s  = last_grant_r;
        cand_s  = last_grant_r;
        found_s = 1'b0;
        for (int i = 1; i <= NUM_INPUTS; i++) begin
            cand_s  = GW'((int'(last_grant_r) + i) % NUM_INPUTS);
            pick_s  = (!found_s && req_s[cand_s]) ? cand_s : pick_s;
            found_s = found_s | req_s[cand_s];
        end
    end

    // Next-state logic and the combinational pass-through of the granted stream.
    always_comb begin
        state_s         = state_r;
        grant_s         = grant_r;
        last_grant_s    = last_grant_r;
        pkt_cnt_s       = pkt_cnt_r;
        s_axis_tready_o = {NUM_INPUTS{1'b0}};
        m_axis_tid_o    = {ID_WIDTH{1'b0}};
        m_axis_tdata_o  = {DATA_WIDTH{1'b0}};
        m_axis_tkeep_o  = {TKEEP_WIDTH{1'b0}};
        m_axis_tlast_o  = 1'b0;
        m_axis_tvalid_o = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    grant_s = pick_s;
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                m_axis_tid_o             = tid_arr_s[grant_r];
                m_axis_tdata_o           = tdata_arr_s[grant_r];
                m_axis_tkeep_o           = tkeep_arr_s[grant_r];
                m_axis_tlast_o           = s_axis_tlast_i[grant_r];
                m_axis_tvalid_o          = s_axis_tvalid_i[grant_r];
                s_axis_tready_o[grant_r] = m_axis_tready_i;
                // Lock is released only by the granted port's tlast handshake.
                if (s_axis_tvalid_i[grant_r] && m_axis_tready_i && s_axis_tlast_i[grant_r]) begin
                    state_s      = ST_IDLE;
                    last_grant_s = grant_r;
                    pkt_cnt_s    = pkt_cnt_r + 32'd1;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and packet-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NUM_INPUTS - 1);
            pkt_cnt_r    <= 32'd0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            pkt_cnt_r    <= pkt_cnt_s;
        end
    end

    assign grant_o   = grant_r;
    assign busy_o    = (state_r == ST_BUSY);
    assign pkt_cnt_o = pkt_cnt_r;

endmodule
